// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, FSM state codes,
// ALU/mux select codes and the packed control word. Used by control, ALU control and datapath.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NONE = 17'd0;

  function automatic logic is_known_opcode(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_main_control_if.sv
// Control-path bundle between the main control FSM (master) and the datapath (slave).
interface mips_mc_main_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [2:0]         alu_op;
  logic [1:0]         pc_source;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control word decode. FETCH is the only state with Mealy terms
// (ir_write/pc_write follow mem_ready); every other output is purely a function of state.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_word_t ctrl
);

  // Control word per state; unlisted fields and unused codes stay all-zero.
  always_comb begin
    ctrl = CTRL_NONE;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/mips_mc_main_control.sv
// Multi-cycle MIPS32 main control FSM: state register, next-state logic and illegal-opcode flag.
// Build option MIPS_ILLEGAL_TRAP_EN: unknown opcodes park in TRAP with a sticky illegal_op.
module mips_mc_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_mc_main_control_if.master bus
);

  state_t     state_q;
  state_t     state_d;
  ctrl_word_t ctrl_s;

  // State register; async reset drops every strobe at once since outputs decode from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection; unused codes recover through FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else               state_d = S_FETCH;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      // IR holds the opcode stable, so MEMADR can re-inspect it to pick the access type.
      S_MEMADR: begin
        if (bus.opcode == OP_SW) state_d = S_MEMWR;
        else                     state_d = S_MEMRD;
      end
      S_MEMRD: begin
        if (bus.mem_ready) state_d = S_MEMWB;
        else               state_d = S_MEMRD;
      end
      S_MEMWR: begin
        if (bus.mem_ready) state_d = S_FETCH;
        else               state_d = S_MEMWR;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP: state_d = S_FETCH;
`ifdef MIPS_ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

`ifdef MIPS_ILLEGAL_TRAP_EN
  logic illegal_op_q;
  logic illegal_op_d;

  // Flag is set on the DECODE that diverts to TRAP and is cleared only by reset.
  always_comb begin
    illegal_op_d = illegal_op_q;
    if (state_q == S_DECODE && !is_known_opcode(bus.opcode)) illegal_op_d = 1'b1;
    else                                                      illegal_op_d = illegal_op_q;
  end

  // Sticky illegal-opcode flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_op_q <= 1'b0;
    else        illegal_op_q <= illegal_op_d;
  end

  assign bus.illegal_op = illegal_op_q;
`else
  assign bus.illegal_op = 1'b0;
`endif

  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl_s)
  );

  assign bus.pc_write      = ctrl_s.pc_write;
  assign bus.pc_write_cond = ctrl_s.pc_write_cond;
  assign bus.iord          = ctrl_s.iord;
  assign bus.mem_read      = ctrl_s.mem_read;
  assign bus.mem_write     = ctrl_s.mem_write;
  assign bus.ir_write      = ctrl_s.ir_write;
  assign bus.reg_dst       = ctrl_s.reg_dst;
  assign bus.mem_to_reg    = ctrl_s.mem_to_reg;
  assign bus.reg_write     = ctrl_s.reg_write;
  assign bus.alu_src_a     = ctrl_s.alu_src_a;
  assign bus.alu_src_b     = ctrl_s.alu_src_b;
  assign bus.alu_op        = ctrl_s.alu_op;
  assign bus.pc_source     = ctrl_s.pc_source;
  assign bus.state         = STATE_W'(state_q);

endmodule
